// File: rtl/bj_pkg.sv
// ============================================================================
// Module   : bj_pkg
// Purpose  : Shared branch funct3 codes, BHT counter type and its update rule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bj_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
    logic [1:0] v;
    v = cnt;
    if (taken && (v != 2'b11)) begin
      v = v + 2'b01;
    end else if (!taken && (v != 2'b00)) begin
      v = v - 2'b01;
    end
    return bht_cnt_t'(v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predict_resolve_bht_table.sv
// ============================================================================
// Module   : bht_table
// Purpose  : Direct-mapped table of 2-bit saturating counters, async reset,
//            one combinational read port and one synchronous update port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_table
  import bj_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_cnt_t         rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int DEPTH = 2 ** IDX_W;

  bht_cnt_t bht_q [DEPTH];

  // Reads see only the registered table, so a same-cycle update appears next cycle.
  assign rd_cnt_o = bht_q[rd_idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i] <= bht_cnt_t'(CNT_INIT);
      end
    end else if (wr_en_i) begin
      bht_q[wr_idx_i] <= sat_update(bht_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predict_resolve.sv
// ============================================================================
// Module   : branch_predict_resolve
// Purpose  : EX-stage branch/jump resolution, BHT prediction and training,
//            mispredict flagging and performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_resolve
  import bj_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         PERF_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   i_f_pc,
  output logic              o_f_pred_taken,
  input  logic              i_ex_valid,
  input  logic [XLEN-1:0]   i_ex_pc,
  input  logic              i_Branch,
  input  logic              i_Jump,
  input  logic [2:0]        i_Funct3,
  input  logic              i_Zero,
  input  logic              i_Lt,
  input  logic              i_Ltu,
  input  logic              i_ex_pred_taken,
  output logic              o_B_J_result,
  output logic              o_mispredict,
  output logic              o_illegal_br,
  output logic [PERF_W-1:0] o_br_count,
  output logic [PERF_W-1:0] o_mp_count
);

  logic [IDX_W-1:0]  w_f_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  bht_cnt_t          w_f_cnt;
  logic              w_taken;
  logic              w_illegal;
  logic              w_resolved;
  logic              w_train;
  logic [PERF_W-1:0] br_count_q, br_count_d;
  logic [PERF_W-1:0] mp_count_q, mp_count_d;
  logic              w_unused_pc;

  // Word-aligned PCs: bits [1:0] and upper bits do not select an entry.
  assign w_f_idx     = i_f_pc[IDX_W+1:2];
  assign w_ex_idx    = i_ex_pc[IDX_W+1:2];
  assign w_unused_pc = ^{i_f_pc[XLEN-1:IDX_W+2], i_f_pc[1:0],
                         i_ex_pc[XLEN-1:IDX_W+2], i_ex_pc[1:0]};

  bht_table #(
    .IDX_W    (IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_bht (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .rd_idx_i   (w_f_idx),
    .rd_cnt_o   (w_f_cnt),
    .wr_en_i    (w_train),
    .wr_idx_i   (w_ex_idx),
    .wr_taken_i (w_taken)
  );

  assign o_f_pred_taken = w_f_cnt[1];

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    if (i_ex_valid) begin
      if (i_Branch) begin
        case (i_Funct3)
          F3_BEQ:  w_taken = i_Zero;
          F3_BNE:  w_taken = ~i_Zero;
          F3_BLT:  w_taken = i_Lt;
          F3_BGE:  w_taken = ~i_Lt;
          F3_BLTU: w_taken = i_Ltu;
          F3_BGEU: w_taken = ~i_Ltu;
          default: w_illegal = 1'b1;
        endcase
      end else if (i_Jump) begin
        w_taken = 1'b1;
      end
    end
  end

  assign w_resolved   = i_ex_valid & (i_Branch | i_Jump) & ~w_illegal;
  assign w_train      = i_ex_valid & i_Branch & ~w_illegal;
  assign o_B_J_result = w_taken;
  assign o_illegal_br = w_illegal;
  assign o_mispredict = w_resolved & (w_taken != i_ex_pred_taken);

  assign br_count_d = w_resolved   ? br_count_q + PERF_W'(1) : br_count_q;
  assign mp_count_d = o_mispredict ? mp_count_q + PERF_W'(1) : mp_count_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign o_br_count = br_count_q;
  assign o_mp_count = mp_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
// ============================================================================
// Module   : tb_branch_predict_resolve
// Purpose  : Directed bench with a reference predictor model and literal pins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] f_pc = '0;
  logic        f_pred;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        br = 1'b0, jmp = 1'b0;
  logic [2:0]  f3 = '0;
  logic        zero = 1'b0, lt = 1'b0, ltu = 1'b0, pred = 1'b0;
  logic        res, mp, ill;
  logic [31:0] br_cnt, mp_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_bht [64];
  int unsigned m_br, m_mp;

  branch_predict_resolve #(
    .XLEN(32), .IDX_W(6), .CNT_INIT(2'b01), .PERF_W(32)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_f_pc(f_pc), .o_f_pred_taken(f_pred),
    .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_Branch(br), .i_Jump(jmp),
    .i_Funct3(f3), .i_Zero(zero), .i_Lt(lt), .i_Ltu(ltu),
    .i_ex_pred_taken(pred), .o_B_J_result(res), .o_mispredict(mp),
    .o_illegal_br(ill), .o_br_count(br_cnt), .o_mp_count(mp_cnt)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {taken, illegal, mispredict} from the architectural branch rules
  function automatic logic [2:0] model_res();
    logic t, il, m;
    t = 1'b0; il = 1'b0;
    if (ex_valid && br) begin
      case (f3)
        3'd0: t = zero;
        3'd1: t = !zero;
        3'd4: t = lt;
        3'd5: t = !lt;
        3'd6: t = ltu;
        3'd7: t = !ltu;
        default: il = 1'b1;
      endcase
    end else if (ex_valid && jmp) begin
      t = 1'b1;
    end
    m = ex_valid && (br || jmp) && !il && (t != pred);
    return {t, il, m};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [2:0] r;
    int         k;
    if (rst) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_br = 0;
      m_mp = 0;
    end else begin
      r = model_res();
      if (ex_valid && (br || jmp) && !r[1]) m_br++;
      if (r[0]) m_mp++;
      if (ex_valid && br && !r[1]) begin
        k = idx_of(ex_pc);
        if (r[2]) m_bht[k] = (m_bht[k] < 3) ? m_bht[k] + 1 : 3;
        else      m_bht[k] = (m_bht[k] > 0) ? m_bht[k] - 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] r;
    r = model_res();
    chk("pred",       f_pred, m_bht[idx_of(f_pc)] >= 2);
    chk("result",     res,    r[2]);
    chk("illegal",    ill,    r[1]);
    chk("mispredict", mp,     r[0]);
    chk("br_count",   br_cnt, m_br);
    chk("mp_count",   mp_cnt, m_mp);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic b, input logic j,
                        input logic [31:0] pc, input logic [2:0] f,
                        input logic z, input logic l, input logic lu, input logic p);
    ex_valid = v; br = b; jmp = j; ex_pc = pc; f3 = f;
    zero = z; lt = l; ltu = lu; pred = p;
  endtask

  logic [2:0] sw_f3  [9] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd0, 3'd4, 3'd7, 3'd2};
  logic       sw_z   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       sw_lt  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       sw_ltu [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       sw_exp [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    #12 rst = 1'b0;
    f_pc = 32'h100;
    #1;
    chk("reset_pred", f_pred, 1'b0);
    chk("reset_br",   br_cnt, 32'd0);
    chk("reset_mp",   mp_cnt, 32'd0);
    step();

    // BEQ taken three times, prediction following fetch
    set_ex(1, 1, 0, 32'h100, 3'd0, 1, 0, 0, 0);
    #2;
    chk("beq1_result", res, 1'b1);
    chk("beq1_mp",     mp,  1'b1);
    step();
    chk("beq1_pred_next", f_pred, 1'b1);
    set_ex(1, 1, 0, 32'h100, 3'd0, 1, 0, 0, 1);
    step();
    step();
    set_ex(0, 0, 0, 32'h0, 3'd0, 0, 0, 0, 0);
    #2;
    chk("beq3_br",   br_cnt, 32'd3);
    chk("beq3_mp",   mp_cnt, 32'd1);
    chk("beq3_pred", f_pred, 1'b1);
    // Saturated at 11: two not-taken land on 01
    set_ex(1, 1, 0, 32'h100, 3'd0, 0, 0, 0, 1);
    step();
    step();
    set_ex(0, 0, 0, 32'h0, 3'd0, 0, 0, 0, 0);
    #2;
    chk("sat_pred", f_pred, 1'b0);
    chk("sat_mp",   mp_cnt, 32'd3);
    step();

    for (int k = 0; k < 9; k++) begin
      set_ex(1, 1, 0, 32'h140 + 32'(k * 4), sw_f3[k], sw_z[k], sw_lt[k], sw_ltu[k], k == 8);
      #2;
      chk("sweep_result", res, sw_exp[k]);
      chk("sweep_illegal", ill, k == 8);
      if (k == 8) chk("illegal_mp", mp, 1'b0);
      step();
    end
    set_ex(0, 0, 0, 32'h0, 3'd0, 0, 0, 0, 0);
    #2;
    chk("sweep_br", br_cnt, 32'd13);
    chk("sweep_mp", mp_cnt, 32'd6);

    f_pc = 32'h108;
    set_ex(1, 0, 1, 32'h108, 3'd0, 0, 0, 0, 0);
    #1;
    chk("jal_result", res, 1'b1);
    chk("jal_mp",     mp,  1'b1);
    step();
    chk("jal_mp_cnt",  mp_cnt, 32'd7);
    chk("jal_no_train", f_pred, 1'b0);
    set_ex(1, 1, 1, 32'h10C, 3'd1, 1, 0, 0, 0);
    #1;
    chk("br_jmp_result", res, 1'b0);
    step();
    set_ex(0, 0, 0, 32'h0, 3'd0, 0, 0, 0, 0);
    f_pc = 32'h140;
    #2;
    chk("pre_rst_pred", f_pred, 1'b1);
    chk("pre_rst_br",   br_cnt, 32'd15);
    rst = 1'b1;
    #1;
    chk("arst_pred", f_pred, 1'b0);
    chk("arst_br",   br_cnt, 32'd0);
    chk("arst_mp",   mp_cnt, 32'd0);
    rst = 1'b0;
    step();

    // 0x200 aliases with 0x100; fetch sees the update one cycle later
    f_pc = 32'h100;
    set_ex(1, 1, 0, 32'h200, 3'd0, 1, 0, 0, 0);
    #2;
    chk("alias_old", f_pred, 1'b0);
    step();
    chk("alias_new", f_pred, 1'b1);
    set_ex(1, 1, 0, 32'h200, 3'd0, 1, 0, 0, 1);
    step();
    set_ex(0, 1, 0, 32'h200, 3'd2, 0, 1, 1, 1);
    #2;
    chk("bubble_result",  res, 1'b0);
    chk("bubble_illegal", ill, 1'b0);
    chk("bubble_mp",      mp,  1'b0);
    step();
    set_ex(0, 1, 0, 32'h200, 3'd0, 0, 0, 0, 1);
    step();
    chk("bubble_br", br_cnt, 32'd2);
    chk("bubble_mp_cnt", mp_cnt, 32'd1);

    // Reset held across an edge carrying a valid mispredicting branch
    set_ex(1, 1, 0, 32'h200, 3'd0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    set_ex(0, 0, 0, 32'h0, 3'd0, 0, 0, 0, 0);
    #1;
    chk("rst_win_br",   br_cnt, 32'd0);
    chk("rst_win_mp",   mp_cnt, 32'd0);
    chk("rst_win_pred", f_pred, 1'b0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
